// File: rtl/prog_loader_pkg.sv
// Shared constants for the byte-stream program loader: FSM encoding, command bytes
// and header field sizes.
package prog_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_LEN   = 3'd2;
    localparam state_t ST_DATA  = 3'd3;
    localparam state_t ST_WRITE = 3'd4;
    localparam state_t ST_RUN   = 3'd5;
    localparam state_t ST_ERROR = 3'd6;

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;
    localparam logic [7:0] CMD_HALT = 8'h04;

    localparam int ADDR_BYTES = 4;
    localparam int LEN_BYTES  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian N-byte accumulator: byte k of a field lands in bits [8k+7:8k].
// acc_nxt shows the value including the byte accepted this cycle; last flags the final byte.
module byte_assembler #(
    parameter int MAXB = 8,
    parameter int CW   = $clog2(MAXB + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                byte_vld,
    input  logic [7:0]          byte_dat,
    input  logic [CW-1:0]       nbytes,
    output logic [8*MAXB-1:0]   acc_dat,
    output logic [8*MAXB-1:0]   acc_nxt,
    output logic                last
);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [8*MAXB-1:0] acc_q, acc_d;

    assign last    = byte_vld && (cnt_q == nbytes - 1'b1);
    assign acc_dat = acc_q;
    assign acc_nxt = acc_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (byte_vld) begin
            // First byte of a field clears stale upper bytes from a longer previous field.
            if (cnt_q == '0) begin
                acc_d = '0;
            end
            for (int i = 0; i < MAXB; i++) begin
                if (cnt_q == CW'(i)) begin
                    acc_d[8*i +: 8] = byte_dat;
                end
            end
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing IMEM/DMEM words and gating the core reset.
// A word is written the cycle after its last byte; in_ready drops only for that write cycle.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IMEM_W = 32,
    parameter int DMEM_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [IMEM_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DMEM_W-1:0] dmem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam int IMEM_B = IMEM_W / 8;
    localparam int DMEM_B = DMEM_W / 8;
    localparam int MAXB   = max_int(max_int(IMEM_B, DMEM_B), ADDR_BYTES);
    localparam int CW     = $clog2(MAXB + 1);
    localparam int AW     = 8 * MAXB;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rem_q, rem_d;
    logic [15:0]       words_q, words_d;
    logic              tgt_dmem_q, tgt_dmem_d;
    logic              core_reset_q, core_reset_d;
    logic              rdy_en_q;

    logic              accept;
    logic              asm_vld;
    logic              asm_last;
    logic [CW-1:0]     asm_n;
    logic [CW-1:0]     bpw;
    logic [AW-1:0]     acc_dat, acc_nxt;
    logic              unused_acc;

    // rdy_en_q keeps in_ready low while reset is held and for the first edge after release.
    assign in_ready = rdy_en_q && (state_q != ST_WRITE);
    assign accept   = in_valid && in_ready;
    assign asm_vld  = accept && (state_q == ST_ADDR || state_q == ST_LEN || state_q == ST_DATA);
    assign bpw      = tgt_dmem_q ? CW'(DMEM_B) : CW'(IMEM_B);

    always_comb begin
        asm_n = bpw;
        case (state_q)
            ST_ADDR: asm_n = CW'(ADDR_BYTES);
            ST_LEN:  asm_n = CW'(LEN_BYTES);
            default: asm_n = bpw;
        endcase
    end

    byte_assembler #(.MAXB(MAXB), .CW(CW)) u_asm (
        .clock    (clock),
        .reset    (reset),
        .byte_vld (asm_vld),
        .byte_dat (in_data),
        .nbytes   (asm_n),
        .acc_dat  (acc_dat),
        .acc_nxt  (acc_nxt),
        .last     (asm_last)
    );

    assign unused_acc = ^acc_nxt;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        words_d    = words_q;
        tgt_dmem_d = tgt_dmem_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (in_data)
                        CMD_IMEM: begin state_d = ST_ADDR; tgt_dmem_d = 1'b0; end
                        CMD_DMEM: begin state_d = ST_ADDR; tgt_dmem_d = 1'b1; end
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_HALT: state_d = ST_IDLE;
                        default:  state_d = ST_ERROR;
                    endcase
                end
            end
            ST_ADDR: begin
                if (asm_last) begin
                    addr_d  = acc_nxt[ADDR_W-1:0];
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (asm_last) begin
                    rem_d   = acc_nxt[15:0];
                    state_d = (acc_nxt[15:0] == 16'd0) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (asm_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(bpw);
                rem_d   = rem_q - 16'd1;
                words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
                state_d = (rem_q == 16'd1) ? ST_IDLE : ST_DATA;
            end
            ST_RUN: begin
                if (accept && in_data == CMD_HALT) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
        core_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            words_q      <= '0;
            tgt_dmem_q   <= 1'b0;
            core_reset_q <= 1'b1;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            words_q      <= words_d;
            tgt_dmem_q   <= tgt_dmem_d;
            core_reset_q <= core_reset_d;
            rdy_en_q     <= 1'b1;
        end
    end

    assign imem_we      = (state_q == ST_WRITE) && !tgt_dmem_q;
    assign dmem_we      = (state_q == ST_WRITE) && tgt_dmem_q;
    assign imem_addr    = addr_q;
    assign dmem_addr    = addr_q;
    assign imem_wdata   = acc_dat[IMEM_W-1:0];
    assign dmem_wdata   = acc_dat[DMEM_W-1:0];
    assign core_reset   = core_reset_q;
    assign busy         = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                          (state_q == ST_DATA) || (state_q == ST_WRITE);
    assign error        = (state_q == ST_ERROR);
    assign words_loaded = words_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader; the write-side counterpart of the bench's end-of-run memory/register dump.
- Receives framed commands over a valid/ready byte interface (UART bridge or bench driver).
- Writes 32-bit instruction words into instruction memory and 64-bit words into data memory.
- Holds the core in reset while loading and releases it on command.

Parameters:
- ADDR_W, 32, memory byte-address width (address field is always 4 bytes on the wire; upper bits truncated when ADDR_W < 32).
- IMEM_W, 32, instruction word width; bytes per instruction word = IMEM_W/8.
- DMEM_W, 64, data word width; bytes per data word = DMEM_W/8.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  byte available.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle.
- imem_addr  out  ADDR_W  byte address of the instruction word.
- imem_wdata  out  IMEM_W  instruction word.
- dmem_we  out  1  data memory write strobe, one cycle.
- dmem_addr  out  ADDR_W  byte address of the data word.
- dmem_wdata  out  DMEM_W  data word.
- core_reset  out  1  active-high reset to full_machine.
- busy  out  1  frame in progress (not IDLE/RUN/ERROR).
- error  out  1  sticky bad-command flag.
- words_loaded  out  16  total words written since reset.

Behaviour:
- Byte transfer: a byte is consumed only when in_valid && in_ready are both high on a rising clock edge.
- Reset (reset low, asynchronous):
  - state=IDLE, core_reset=1, all strobes/addr/wdata=0.
  - error=0, words_loaded=0, in_ready=0 during reset.
- Frame format (all multi-byte fields little-endian):
  - CMD (1 byte), then for CMD 0x01/0x02: ADDR (4 bytes), LEN (2 bytes, word count), then LEN words.
- Commands:
  - 0x01: load instruction words.
  - 0x02: load data words.
  - 0x03: RUN.
  - 0x04: HALT (valid only in RUN; ignored in IDLE).
- States: IDLE, ADDR, LEN, DATA, WRITE, RUN, ERROR.
- IDLE:
  - in_ready=1.
  - 0x01/0x02 -> ADDR; target latched.
  - 0x03 -> RUN; core_reset falls the cycle after the byte is accepted.
  - 0x04 -> stay in IDLE.
  - Any other value -> ERROR.
- ADDR: 4 bytes assembled LSB first -> LEN.
- LEN: 2 bytes assembled; if LEN==0 -> IDLE with no writes, else -> DATA.
- DATA:
  - Shift register collects IMEM_W/8 or DMEM_W/8 bytes, LSB first.
  - On the last byte -> WRITE.
- WRITE:
  - Exactly one cycle; in_ready=0.
  - Relevant *_we=1 with the current addr and assembled wdata.
  - Then addr += bytes-per-word, remaining -= 1, words_loaded += 1 (saturates at 0xFFFF).
  - Next state: remaining==0 -> IDLE, else -> DATA.
- Address wrap: addr increments modulo 2^ADDR_W; no error on wrap.
- Write latency: first strobe occurs the cycle after the final byte of a word is accepted.
- RUN:
  - core_reset=0, in_ready=1.
  - 0x04 -> core_reset=1 next cycle, -> IDLE.
  - Every other byte is dropped.
- ERROR:
  - error=1, core_reset=1, in_ready=1; all bytes drained and ignored.
  - Exit only via reset.
- Never both imem_we and dmem_we in the same cycle.
- Strobes are 0 in every state other than WRITE.
- in_valid dropping mid-frame: state holds indefinitely; no timeout.
- Reset mid-frame: partial word discarded, no write issued, core_reset=1 immediately.
- busy=1 in ADDR, LEN, DATA, WRITE.

Decomposition:
- Package prog_loader_pkg:
  - state enum.
  - command byte constants CMD_IMEM=0x01, CMD_DMEM=0x02, CMD_RUN=0x03, CMD_HALT=0x04.
  - byte counts for the ADDR and LEN fields.
- One sub-module: byte_assembler.
  - Parameterised N-byte little-endian shift register with byte count and a last-byte flag.
  - Reused for ADDR, LEN and DATA.

Test Plan:
1. Stream 01, 00 00 00 00, 02 00, 20 08 00 05, 20 09 00 07:
   - imem_we pulses at addr 0x0 with 0x05000820 and at 0x4 with 0x07000920.
   - words_loaded=2; back in IDLE; core_reset still 1.
2. Stream 02, 10 00 00 00, 01 00, 8 bytes 11..88:
   - dmem_we at 0x10 with 0x8877665544332211.
   - imem_we never asserted.
3. After case 1, send 03:
   - core_reset falls the next cycle; busy=0.
   - A following byte 0x55 is ignored.
   - Byte 04 raises core_reset and returns to IDLE.
4. Send 07:
   - error=1, core_reset=1; later 01 frames produce no strobes.
   - Assert reset low: error clears.
5. Send 01, addr FC FF FF FF, LEN 02, two words:
   - Writes at 0xFFFFFFFC then 0x00000000 (wrap).
   - LEN=0 frame: no strobe, returns to IDLE.
6. Toggle in_valid randomly and assert reset low mid-DATA:
   - No strobe for the partial word; all outputs at reset values.
   - in_ready=0 during every WRITE cycle.
